usb_rx_decoder: RTL and testbench

Receive-side counterpart of the transmitter's NRZI encoder. Samples the synchronized D+/D- pair once per bit strobe and classifies the line as J, K, SE0 or SE1. During a packet it NRZI-decodes each bit, removes stuffed bits, deserializes bits LSB-first into bytes, and flags EOP, bit-stuff violations and illegal line states. Sits between the receive bit-timer/synchronizer and the packet-layer FSM.

---
 rtl/usb_rx_pkg.sv | 40 ++++
 rtl/usb_rx_deser.sv | 58 +++++
 rtl/usb_rx_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// USB receive decoder shared types: line states, FSM states, D+/D- encodings.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package usb_rx_pkg;

    // Classified line state for one bit-centre sample
    typedef enum logic [1:0] {
        LS_J,
        LS_K,
        LS_SE0,
        LS_SE1
    } line_state_t;

    // Receive FSM states
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        EOP_WAIT,
        ABORT
    } rx_state_t;

    // Line encodings as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    // Map the synchronized D+/D- pair to a line state
    function automatic line_state_t classify_line(input logic dp, input logic dm);
        line_state_t ls;
        case ({dp, dm})
            LINE_J:   ls = LS_J;
            LINE_K:   ls = LS_K;
            LINE_SE0: ls = LS_SE0;
            default:  ls = LS_SE1;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_rx_deser.sv
// LSB-first 8-bit deserializer with wrap-around bit counter and synchronous clear.
// Latency: byte_valid/rx_byte update one cycle after the 8th shift_en.
// Backpressure: none; every shift_en is consumed, clr drops any partial byte.
module usb_rx_deser
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       bit_in,
    input  logic       clr,
    output logic [7:0] rx_byte,
    output logic       byte_valid
);

    logic [7:0] sr_q,   sr_d;
    logic [2:0] cnt_q,  cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       bv_q,   bv_d;

    // Next-state: shift new bit in at the MSB so the first bit ends up at bit 0
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        byte_d = byte_q;
        bv_d   = 1'b0;
        if (clr) begin
            sr_d  = 8'h00;
            cnt_d = 3'd0;
        end else if (shift_en) begin
            sr_d  = {bit_in, sr_q[7:1]};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_d = {bit_in, sr_q[7:1]};
                bv_d   = 1'b1;
            end
        end
    end

    // Deserializer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= 8'h00;
            cnt_q  <= 3'd0;
            byte_q <= 8'h00;
            bv_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            byte_q <= byte_d;
            bv_q   <= bv_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = bv_q;

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive line decoder: line classify, NRZI decode, destuff, deserialize, EOP/error detect.
// Latency: all outputs registered, pulses appear the cycle after the strobe sample.
// Backpressure: none; the line is sampled only on shift_strobe and never stalled.
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp_in,
    input  logic       dm_in,
    input  logic       shift_strobe,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_active,
    output logic       eop,
    output logic       stuff_err,
    output logic       line_err
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int SE0_W  = (EOP_SE0_BITS < 1) ? 1 : $clog2(EOP_SE0_BITS + 1);
    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
    localparam logic [SE0_W-1:0]  SE0_MAX   = SE0_W'(EOP_SE0_BITS);

    rx_state_t         state_q,     state_d;
    line_state_t       prev_q,      prev_d;
    logic [ONES_W-1:0] ones_q,      ones_d;
    logic [SE0_W-1:0]  se0_q,       se0_d;
    logic              rx_active_q, rx_active_d;
    logic              bit_out_q,   bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              eop_q,       eop_d;
    logic              stuff_err_q, stuff_err_d;
    logic              line_err_q,  line_err_d;

    line_state_t       ls;
    logic              dec_bit;
    logic              shift_en;
    logic              deser_clr;

    assign ls = classify_line(dp_in, dm_in);

    // Next-state and output decode; only acts on a strobe sample.
    // The SYNC pattern's trailing 1 counts toward the ones run, as on the wire.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        ones_d      = ones_q;
        se0_d       = se0_q;
        rx_active_d = rx_active_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        eop_d       = 1'b0;
        stuff_err_d = 1'b0;
        line_err_d  = 1'b0;
        shift_en    = 1'b0;
        deser_clr   = 1'b0;
        // NRZI: no transition decodes as 1
        dec_bit     = (ls == prev_q);

        if (shift_strobe) begin
            case (state_q)
                IDLE: begin
                    // Only a K (J->K transition) starts a packet; it is data bit 0
                    if (ls == LS_K) begin
                        state_d     = ACTIVE;
                        rx_active_d = 1'b1;
                        prev_d      = LS_K;
                        bit_out_d   = 1'b0;
                        bit_valid_d = 1'b1;
                        shift_en    = 1'b1;
                        ones_d      = '0;
                    end
                end

                ACTIVE: begin
                    case (ls)
                        LS_J, LS_K: begin
                            prev_d = ls;
                            if (ones_q == STUFF_MAX) begin
                                if (!dec_bit) begin
                                    // Stuffed zero: drop it silently
                                    ones_d = '0;
                                end else begin
                                    stuff_err_d = 1'b1;
                                    state_d     = ABORT;
                                    rx_active_d = 1'b0;
                                    deser_clr   = 1'b1;
                                    se0_d       = '0;
                                end
                            end else begin
                                bit_out_d   = dec_bit;
                                bit_valid_d = 1'b1;
                                shift_en    = 1'b1;
                                ones_d      = dec_bit ? (ones_q + ONES_W'(1)) : '0;
                            end
                        end
                        LS_SE0: begin
                            state_d = EOP_WAIT;
                            se0_d   = SE0_W'(1);
                        end
                        default: begin
                            line_err_d  = 1'b1;
                            state_d     = ABORT;
                            rx_active_d = 1'b0;
                            deser_clr   = 1'b1;
                            se0_d       = '0;
                        end
                    endcase
                end

                EOP_WAIT: begin
                    if (ls == LS_SE0) begin
                        if (se0_q < SE0_MAX) begin
                            se0_d = se0_q + SE0_W'(1);
                        end
                    end else if (ls == LS_J && se0_q >= SE0_MAX) begin
                        eop_d       = 1'b1;
                        state_d     = IDLE;
                        rx_active_d = 1'b0;
                        prev_d      = LS_J;
                        ones_d      = '0;
                        se0_d       = '0;
                        deser_clr   = 1'b1;
                    end else begin
                        // Short SE0 run, K after SE0, or SE1
                        line_err_d  = 1'b1;
                        state_d     = ABORT;
                        rx_active_d = 1'b0;
                        deser_clr   = 1'b1;
                        se0_d       = '0;
                    end
                end

                default: begin
                    // ABORT: se0_q acts as a "seen SE0" flag; SE0 then J recovers
                    rx_active_d = 1'b0;
                    if (ls == LS_SE0) begin
                        se0_d = SE0_W'(1);
                    end else if (ls == LS_J && se0_q != '0) begin
                        state_d   = IDLE;
                        prev_d    = LS_J;
                        ones_d    = '0;
                        se0_d     = '0;
                        deser_clr = 1'b1;
                    end else begin
                        se0_d = '0;
                    end
                end
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_q      <= LS_J;
            ones_q      <= '0;
            se0_q       <= '0;
            rx_active_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            eop_q       <= 1'b0;
            stuff_err_q <= 1'b0;
            line_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            ones_q      <= ones_d;
            se0_q       <= se0_d;
            rx_active_q <= rx_active_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            eop_q       <= eop_d;
            stuff_err_q <= stuff_err_d;
            line_err_q  <= line_err_d;
        end
    end

    usb_rx_deser u_deser (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .bit_in     (dec_bit),
        .clr        (deser_clr),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid)
    );

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign rx_active = rx_active_q;
    assign eop       = eop_q;
    assign stuff_err = stuff_err_q;
    assign line_err  = line_err_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: line levels in, pulse counts and bytes checked.
// Latency: outputs observed half a cycle after the strobe-capturing edge.
// Backpressure: none.
module tb_usb_rx_decoder;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       dp_in;
    logic       dm_in;
    logic       shift_strobe;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_active;
    logic       eop;
    logic       stuff_err;
    logic       line_err;

    int n_chk = 0;
    int n_err = 0;

    // Running pulse counters (one count per cycle a pulse is high)
    int c_bv = 0, c_byv = 0, c_eop = 0, c_se = 0, c_le = 0, c_orph = 0;
    int b_bv, b_byv, b_eop, b_se, b_le;

    always #5 clk = ~clk;

    usb_rx_decoder #(.STUFF_LEN(6), .EOP_SE0_BITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .dp_in        (dp_in),
        .dm_in        (dm_in),
        .shift_strobe (shift_strobe),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .rx_byte      (rx_byte),
        .byte_valid   (byte_valid),
        .rx_active    (rx_active),
        .eop          (eop),
        .stuff_err    (stuff_err),
        .line_err     (line_err)
    );

    // Pulse monitor, sampled shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (bit_valid)  c_bv++;
        if (byte_valid) c_byv++;
        if (eop)        c_eop++;
        if (stuff_err)  c_se++;
        if (line_err)   c_le++;
        if (byte_valid && !bit_valid) c_orph++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_bv = c_bv; b_byv = c_byv; b_eop = c_eop; b_se = c_se; b_le = c_le;
    endtask

    task automatic drive(input line_state_t l);
        case (l)
            LS_J:    {dp_in, dm_in} = 2'b10;
            LS_K:    {dp_in, dm_in} = 2'b01;
            LS_SE0:  {dp_in, dm_in} = 2'b00;
            default: {dp_in, dm_in} = 2'b11;
        endcase
    endtask

    // One strobe sample; returns half a cycle after the capturing edge
    task automatic send(input line_state_t l);
        @(negedge clk);
        drive(l);
        shift_strobe = 1'b1;
        @(negedge clk);
        shift_strobe = 1'b0;
    endtask

    // Levels as characters: J, K, 0 = SE0, 1 = SE1
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "J":     send(LS_J);
                "K":     send(LS_K);
                "0":     send(LS_SE0);
                default: send(LS_SE1);
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        dp_in = 1'b1;
        dm_in = 1'b0;
        shift_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {17'd0, bit_out, bit_valid, rx_byte, byte_valid,
                              rx_active, eop, stuff_err, line_err}, 32'd0);
        rst = 1'b0;

        // Idle J and stray SE0 are ignored
        snap();
        for (int i = 0; i < 20; i++) send(LS_J);
        send_str("00J");
        chk("idle_pulses", (c_bv - b_bv) + (c_byv - b_byv) + (c_eop - b_eop)
                           + (c_se - b_se) + (c_le - b_le), 0);
        chk("idle_active", rx_active, 0);

        // SYNC: first K is data bit 0, visible the cycle after the strobe
        snap();
        send(LS_K);
        chk("sop_active", rx_active, 1);
        chk("sop_bit", {bit_valid, bit_out}, 2'b10);
        send_str("JKJKJKK");
        chk("sync_bv", c_bv - b_bv, 8);
        chk("sync_byv", c_byv - b_byv, 1);
        chk("sync_byte", rx_byte, 8'h80);

        // Data byte 0x62 then a clean EOP
        snap();
        send_str("JJKJKKKJ");
        chk("d62_bv", c_bv - b_bv, 8);
        chk("d62_byte", rx_byte, 8'h62);
        snap();
        send_str("00J");
        chk("eop_pulse", c_eop - b_eop, 1);
        chk("eop_active", rx_active, 0);
        chk("eop_nobyte", c_byv - b_byv, 0);
        chk("eop_noerr", c_le - b_le, 0);

        // Stuffing: SYNC's last 1 plus five K's make six ones; next J is stuffed
        send_str("KJKJKJKK");
        snap();
        send_str("KKKKKJJJJ");
        chk("stuff_bv", c_bv - b_bv, 8);
        chk("stuff_byte", rx_byte, 8'hFF);
        chk("stuff_noerr", c_se - b_se, 0);
        send_str("00J");

        // Stuff violation: sixth K after SYNC carries a 1 in the stuff slot
        send_str("KJKJKJKK");
        snap();
        send_str("KKKKKK");
        chk("serr_pulse", c_se - b_se, 1);
        chk("serr_active", rx_active, 0);
        chk("serr_bv", c_bv - b_bv, 5);
        chk("serr_nobyte", c_byv - b_byv, 0);
        snap();
        send_str("K00J");
        chk("abort_noeop", c_eop - b_eop, 0);
        chk("abort_inactive", rx_active, 0);
        send(LS_K);
        chk("restart_active", rx_active, 1);
        send_str("JKJKJKK");
        chk("restart_byte", rx_byte, 8'h80);
        chk("restart_byv", c_byv - b_byv, 1);
        send_str("00J");

        // SE1 during packet
        send_str("KJKJKJKK");
        snap();
        send(LS_SE1);
        chk("se1_lerr", c_le - b_le, 1);
        chk("se1_active", rx_active, 0);
        send_str("0J");
        chk("se1_noeop", c_eop - b_eop, 0);

        // Single SE0 then K
        send_str("KJKJKJKK");
        snap();
        send_str("0K");
        chk("se0k_lerr", c_le - b_le, 1);
        chk("se0k_active", rx_active, 0);
        send_str("0J");

        // Single SE0 then J: run shorter than the EOP minimum
        send_str("KJKJKJKK");
        snap();
        send_str("0J");
        chk("se0j_lerr", c_le - b_le, 1);
        chk("se0j_noeop", c_eop - b_eop, 0);
        send_str("0J");

        // Async reset after three data bits
        send_str("KJKJKJKK");
        send_str("JJK");
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {17'd0, bit_out, bit_valid, rx_byte, byte_valid,
                               rx_active, eop, stuff_err, line_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        snap();
        send_str("KJKJKJKK");
        chk("postrst_byte", rx_byte, 8'h80);
        chk("postrst_bv", c_bv - b_bv, 8);
        chk("postrst_pulses", (c_eop - b_eop) + (c_se - b_se) + (c_le - b_le), 0);

        // Strobe held low for 50 cycles mid-byte while the line wanders
        send_str("JJKJ");
        snap();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            dp_in = 1'($urandom_range(0, 1));
            dm_in = 1'($urandom_range(0, 1));
        end
        chk("gap_pulses", (c_bv - b_bv) + (c_byv - b_byv) + (c_eop - b_eop)
                          + (c_se - b_se) + (c_le - b_le), 0);
        chk("gap_active", rx_active, 1);
        send_str("KKKJ");
        chk("gap_byte", rx_byte, 8'h62);
        chk("gap_byv", c_byv - b_byv, 1);
        snap();
        send_str("00J");
        chk("gap_eop", c_eop - b_eop, 1);

        chk("byte_with_bit", c_orph, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
